// File: rtl/btn_updown_counter_2b.sv
// btn_updown_counter_2b: two active-low push-buttons -> debounced up/down 2-bit count.
// Latency: a stable press moves the count on edge DEBOUNCE_CYCLES+3 after the first low sample.
// Backpressure: none; buttons are level inputs and the count/step outputs are free-running.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_inc_n  raw increment button, active-low, asynchronous to clk
//   btn_dec_n  raw decrement button, active-low, asynchronous to clk
//   yb1, yb0   registered count {MSB, LSB} for the seven-segment decoder
//   step       one-cycle pulse on the cycle the count value changes
//
// Configuration macro: BTN_COUNTER_SAT_EN
//   defined   -> count saturates at 0 and 3 (no step when blocked)
//   undefined -> count wraps modulo 4

// btn_debounce: 2-flop synchroniser plus press/release debounce FSM for one button.
// Latency: press flag on edge DEBOUNCE_CYCLES+3 after the raw input first samples low.
// Backpressure: none; press is a single-cycle flag with no handshake.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Synchroniser flops reset to the released level so a reset never
  // looks like a press edge.
  logic sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // press is decided combinationally on the transition into PRESSED so the
  // count register downstream updates on that same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!sync2) begin
          state_nxt = DEB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        if (sync2) begin
          state_nxt = RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (sync2) begin
          state_nxt = DEB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DEB_RELEASE: begin
        if (!sync2) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// btn_updown_counter_2b: debounced inc/dec buttons drive a registered 2-bit count.
// Latency: count and step update on the same edge the debouncer accepts a press.
// Backpressure: none; simultaneous accepted presses cancel and hold the count.
module btn_updown_counter_2b #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc_n,
  input  logic btn_dec_n,
  output logic yb1,
  output logic yb0,
  output logic step
);

  logic press_inc, press_dec;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_inc_n),
    .press (press_inc)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_dec_n),
    .press (press_dec)
  );

  logic [1:0] cnt_q, cnt_nxt;
  logic       step_q, step_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    unique case ({press_inc, press_dec})
      2'b10: begin
`ifdef BTN_COUNTER_SAT_EN
        cnt_nxt = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
`else
        cnt_nxt = cnt_q + 2'd1;
`endif
      end
      2'b01: begin
`ifdef BTN_COUNTER_SAT_EN
        cnt_nxt = (cnt_q == 2'd0) ? cnt_q : cnt_q - 2'd1;
`else
        cnt_nxt = cnt_q - 2'd1;
`endif
      end
      default: cnt_nxt = cnt_q;  // none, or both cancelling
    endcase
    // Step follows an actual value change, so a saturated press is silent.
    step_nxt = (cnt_nxt != cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      step_q <= step_nxt;
    end
  end

  assign yb1  = cnt_q[1];
  assign yb0  = cnt_q[0];
  assign step = step_q;

endmodule

// File: tb/tb_btn_updown_counter_2b.sv
module tb_btn_updown_counter_2b;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc_n = 1'b1;
  logic btn_dec_n = 1'b1;
  logic yb1, yb0, step;

  btn_updown_counter_2b #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc_n (btn_inc_n),
    .btn_dec_n (btn_dec_n),
    .yb1       (yb1),
    .yb0       (yb0),
    .step      (step)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  // A button's level is seen two edges late. A debounced state flips once the
  // seen level has disagreed with it on D+1 consecutive edges; a flip to
  // "pressed" is an accepted press.
  int         cyc = 0;
  int         m_cnt = 0;
  logic [1:0] dly1 = 2'b11, dly2 = 2'b11;
  logic [1:0] held = 2'b00;
  int         run[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      dly1  = 2'b11;
      dly2  = 2'b11;
      held  = 2'b00;
      run   = '{0, 0};
    end else begin
      logic [1:0] raw, acc;
      int         nc;
      cyc++;
      raw = {btn_dec_n, btn_inc_n};
      acc = 2'b00;
      for (int b = 0; b < 2; b++) begin
        logic lvl;
        lvl = dly2[b];
        dly2[b] = dly1[b];
        dly1[b] = raw[b];
        if (lvl == held[b]) run[b]++;  // seen level disagrees with debounced state
        else run[b] = 0;
        if (run[b] == D + 1) begin
          held[b] = ~held[b];
          run[b]  = 0;
          if (held[b]) acc[b] = 1'b1;
        end
      end
      nc = m_cnt;
      if (acc == 2'b01) nc = m_cnt + 1;
      else if (acc == 2'b10) nc = m_cnt - 1;
`ifdef BTN_COUNTER_SAT_EN
      if (nc > 3) nc = 3;
      if (nc < 0) nc = 0;
`else
      nc = (nc + 4) % 4;
`endif
      if (nc != m_cnt) begin
        exp_t e;
        e.cyc = cyc;
        e.val = 2'(nc);
        exp_q.push_back(e);
      end
      m_cnt = nc;
    end
  end

  // ---------------- monitor ----------------
  int steps_seen = 0;
  int last_step_cyc = -1;

  always @(negedge clk) begin
    if (step === 1'b1) begin
      steps_seen++;
      last_step_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_step cyc=%0d got=%b want=no step", cyc, {yb1, yb0});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== {yb1, yb0}) begin
          miscompares++;
          $display("FAIL step cyc=%0d got=%b want cyc=%0d val=%b", cyc, {yb1, yb0}, e.cyc, e.val);
        end
      end
    end else begin
      vectors++;
      if ({yb1, yb0} !== 2'(m_cnt) || step !== 1'b0) begin
        miscompares++;
        $display("FAIL hold cyc=%0d got=%b step=%b want=%b step=0", cyc, {yb1, yb0}, step, 2'(m_cnt));
      end
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_step cyc=%0d want val=%b at cyc=%0d", cyc, e.val, e.cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic inc_n, input logic dec_n, input int ncyc);
    btn_inc_n = inc_n;
    btn_dec_n = dec_n;
    repeat (ncyc) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int s0, c0;

  initial begin
    @(posedge clk);
    #2;
    do_reset();
    check("reset_count", int'({yb1, yb0}), 0);
    check("reset_step", int'(step), 0);

    // Held increment: one step at edge D+3, nothing more while held.
    s0 = steps_seen;
    c0 = cyc + 1;
    drive(1'b0, 1'b1, 20);
    check("hold_latency", last_step_cyc, c0 + D + 2);
    drive(1'b1, 1'b1, 10);
    check("hold_steps", steps_seen - s0, 1);
    check("hold_count", int'({yb1, yb0}), 1);

    // Four clean increments.
    do_reset();
    s0 = steps_seen;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 10);
      drive(1'b1, 1'b1, 10);
    end
`ifdef BTN_COUNTER_SAT_EN
    check("inc4_steps", steps_seen - s0, 3);
    check("inc4_count", int'({yb1, yb0}), 3);
`else
    check("inc4_steps", steps_seen - s0, 4);
    check("inc4_count", int'({yb1, yb0}), 0);
`endif

    // Decrement from reset.
    do_reset();
    s0 = steps_seen;
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
`ifdef BTN_COUNTER_SAT_EN
    check("dec_steps", steps_seen - s0, 0);
    check("dec_count", int'({yb1, yb0}), 0);
`else
    check("dec_steps", steps_seen - s0, 1);
    check("dec_count", int'({yb1, yb0}), 3);
`endif

    // Bounce: short low pulses never qualify.
    do_reset();
    s0 = steps_seen;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 3);
      drive(1'b1, 1'b1, 1);
    end
    drive(1'b1, 1'b1, 10);
    check("bounce_steps", steps_seen - s0, 0);
    check("bounce_count", int'({yb1, yb0}), 0);

    // Simultaneous press cancels; a later lone inc still counts.
    do_reset();
    s0 = steps_seen;
    drive(1'b0, 1'b0, 10);
    check("both_steps", steps_seen - s0, 0);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    check("both_then_inc_steps", steps_seen - s0, 1);
    check("both_then_inc_count", int'({yb1, yb0}), 1);

    // Reset during DEB_PRESS with the button still held.
    do_reset();
    drive(1'b0, 1'b1, 4);
    check("pre_rst_count", int'({yb1, yb0}), 0);
    s0 = steps_seen;
    do_reset();
    c0 = cyc + 1;
    drive(1'b0, 1'b1, 15);
    check("rst_mid_latency", last_step_cyc, c0 + D + 2);
    drive(1'b1, 1'b1, 10);
    check("rst_mid_steps", steps_seen - s0, 1);
    check("rst_mid_count", int'({yb1, yb0}), 1);

    // Random phase: both buttons toggle with random hold times, rare resets.
    begin
      int  len_i, len_d;
      logic li, ld;
      li = 1'b1;
      ld = 1'b1;
      len_i = 1;
      len_d = 1;
      for (int t = 0; t < 3000; t++) begin
        if (--len_i == 0) begin
          li = ~li;
          len_i = $urandom_range(1, 12);
        end
        if (--len_d == 0) begin
          ld = ~ld;
          len_d = $urandom_range(1, 12);
        end
        if ($urandom_range(0, 499) == 0) do_reset();
        drive(li, ld, 1);
      end
      drive(1'b1, 1'b1, 20);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_updown_counter_2b.md
# btn_updown_counter_2b

Upstream stage of the 2-bit seven-segment display path. Two raw, active-low push-buttons (increment, decrement) are synchronised, debounced and edge-qualified here. The block maintains a registered 2-bit value that is presented on `yb1`/`yb0`, the exact bit pair the display decoder consumes. One accepted press moves the value by exactly one step, regardless of how long the button is held.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000 (1 ms at 50 MHz): consecutive stable synchronised cycles required to accept a press or a release. Legal range 2 to 2^20.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `btn_inc_n`  in  1  raw increment button, active-low, asynchronous to `clk`.
- `btn_dec_n`  in  1  raw decrement button, active-low, asynchronous to `clk`.
- `yb1`  out  1  count bit 1 (MSB), registered.
- `yb0`  out  1  count bit 0 (LSB), registered.
- `step`  out  1  one-cycle pulse, high on the cycle the count changes.

## Operation
- **Synchroniser.** Each button passes through its own 2-flop synchroniser. Synchroniser flops reset to 1 (released).
- **Debounce FSM, one per button.** States are RELEASED, DEB_PRESS, PRESSED and DEB_RELEASE. Each FSM has a debounce counter of width clog2(DEBOUNCE_CYCLES).
  - RELEASED: if the synchronised level is 0, go to DEB_PRESS and clear the counter.
  - DEB_PRESS: if the level is 1, return to RELEASED. If the level is 0 and the counter equals DEBOUNCE_CYCLES-1, go to PRESSED and assert the internal `press` flag for one cycle. Otherwise increment the counter.
  - PRESSED: if the level is 1, go to DEB_RELEASE and clear the counter.
  - DEB_RELEASE: if the level is 0, return to PRESSED. If the level is 1 and the counter equals DEBOUNCE_CYCLES-1, go to RELEASED. Otherwise increment the counter.
- **Count register.** The 2-bit count `{yb1,yb0}` updates on the edge after a `press` flag is asserted.
  - `press_inc` alone: count = count + 1.
  - `press_dec` alone: count = count - 1.
  - Both in the same cycle: count holds and `step` stays 0.
  - Neither: count holds.
- **Arithmetic.** Modulo 4 by default (3 + 1 = 0, 0 - 1 = 3). See Configuration for the alternative.
- **Step pulse.** `step` is registered alongside the count and is 1 only on cycles where the count value actually changed.
- **Holding a button.** A held button produces exactly one step. Another step from that button requires a full debounced release followed by a new press.
- **Reset values.** Reset forces both FSMs to RELEASED and both debounce counters to 0. Outputs reset to `yb1`=0, `yb0`=0, `step`=0.
- **Reset mid-operation.** Any in-progress debounce is discarded. If a button is still held after reset deasserts, it is debounced again as a fresh press and produces one step.

## Timing
- **Press latency.** Measure from the first rising edge that samples a raw button low. With the button held stable, `yb1`/`yb0` and `step` change at edge DEBOUNCE_CYCLES+3: 2 edges of synchroniser, 1 edge for the RELEASED to DEB_PRESS transition, then DEBOUNCE_CYCLES edges of debounce. The count updates on the edge that also asserts `press`.
- **Glitch rejection.** A low glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no step and leaves the FSM back in RELEASED.
- **Release time.** The minimum time between two accepted presses of one button is DEBOUNCE_CYCLES cycles pressed plus DEBOUNCE_CYCLES cycles released, plus synchroniser delay.
- **Output stability.** Outputs are glitch-free and change only on `clk` rising edges.

## Configuration
- **`BTN_COUNTER_SAT_EN` defined:** arithmetic saturates.
  - Increment at 3 holds at 3; decrement at 0 holds at 0.
  - `step` is not asserted when saturation blocks a change.
  - Debouncing and the simultaneous-press rule are unchanged.
- **`BTN_COUNTER_SAT_EN` undefined (default):** modulo-4 wrap as described in Operation.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset with both buttons released: `yb1`,`yb0`,`step` = 0,0,0. Hold `btn_inc_n`=0 for 20 cycles: count = 01 at edge 7, `step` high for that one cycle only, and no further change while held.
- Four clean inc presses, each 10 cycles low and 10 cycles high: count sequence 01, 10, 11, 00 (wrap). With `BTN_COUNTER_SAT_EN`: 01, 10, 11, 11, and no `step` on the fourth press.
- Dec press from reset: count = 11. With `BTN_COUNTER_SAT_EN`: count stays 00 and `step`=0.
- Bounce on inc: 3-cycle low pulses separated by 1-cycle highs, repeated 5 times, then release: count unchanged at 00 and `step` never asserted.
- Both buttons pressed on the same edge and held 10 cycles: count unchanged, `step`=0. Release inc, then re-press inc alone: count +1.
- Hold inc, assert `rst_n`=0 mid-DEB_PRESS for 2 cycles, then deassert with inc still held: outputs 00 during reset, then exactly one step to 01 at DEBOUNCE_CYCLES+3 edges after reset release.
